traffic_cmd_sender: RTL and testbench
=====================================

Name: traffic_cmd_sender

Overview:
- Command-side driver for the `traffic_light` configuration interface; owns `inst_send`, `traffic_sel`, `color_sel`, `start_color`, `input_time` and `is_running`.
- Parses a byte stream from the board UART receiver (`rx_data` / `rx_valid`) into configure, go and stop commands.
- Issues exactly one `inst_send` pulse per accepted configure frame.
- Sits between `uart_rx` and the four `traffic_light` instances, which share its outputs.

Parameters:
- `TIMEOUT_CYCLES`, 100000000, maximum clock cycles allowed between byte 0 and byte 1 of a configure frame (1 s at 100 MHz).
- `CNT_W`, 27, width of the inter-byte timeout counter; must satisfy 2^CNT_W > `TIMEOUT_CYCLES`.

Ports:
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `rx_data` input 8: received byte; valid only when `rx_valid` = 1.
- `rx_valid` input 1: one-cycle strobe per received byte; no backpressure.
- `inst_send` output 1: one-cycle pulse; the configuration fields below are valid in that cycle.
- `traffic_sel` output 2: target light number.
- `color_sel` output 1: 1 = green time, 0 = red time.
- `start_color` output 1: start colour applied to the selected light.
- `input_time` output 4: duration in seconds.
- `is_running` output 1: level; high enables counting in all lights.
- `cmd_err` output 1: one-cycle pulse on a malformed frame or timeout.
- `cmd_count` output 8: number of accepted commands (configure + go + stop); wraps 255 -> 0.

Behaviour:
- Reset values: `inst_send` 0, `traffic_sel` 0, `color_sel` 0, `start_color` 0, `input_time` 4'b1010, `is_running` 0, `cmd_err` 0, `cmd_count` 0, state IDLE, timeout counter 0.
- Header byte fields:
  - [7:6] opcode: 00 = CONFIG, 01 = GO, 10 = STOP, 11 = reserved.
  - [5:4] `traffic_sel`; [3] `color_sel`; [2] `start_color`; [1:0] must be 00.
- CONFIG frames are 2 bytes: the header, then the time byte with [3:0] = `input_time`.
  - Time byte [7:4] must be 0000 (see Optional Feature).
- GO and STOP are 1-byte frames; their bits [5:0] are ignored.
- FSM states IDLE, WAIT_TIME, ISSUE.
- IDLE, on `rx_valid`:
  - CONFIG with [1:0] = 00: latch header fields into holding registers, clear the timeout counter, go to WAIT_TIME.
  - GO: `is_running` <= 1 on the next edge, `cmd_count` += 1, stay in IDLE. GO while already running is accepted and still counted.
  - STOP: `is_running` <= 0, `cmd_count` += 1.
  - Opcode 11 or CONFIG with [1:0] != 00: `cmd_err` pulse, stay in IDLE.
- WAIT_TIME:
  - Timeout counter increments each cycle.
  - On `rx_valid` with a legal time byte: latch `input_time`, go to ISSUE.
  - On `rx_valid` with an illegal time byte: `cmd_err` pulse, return to IDLE, output fields unchanged.
  - If the counter reaches `TIMEOUT_CYCLES`-1 with no `rx_valid`: `cmd_err` pulse, return to IDLE.
  - `rx_valid` in the same cycle as the timeout: the byte wins and no error is raised.
- ISSUE (exactly 1 cycle):
  - Drive the held `traffic_sel`, `color_sel`, `start_color`, `input_time` onto the outputs with `inst_send` = 1; `cmd_count` += 1; return to IDLE.
  - An `rx_valid` arriving during ISSUE is decoded as a header byte, exactly as in IDLE.
- Latency: `inst_send` is registered high on the clock edge after the cycle in which the time byte's `rx_valid` is sampled.
- Output fields hold their last issued values between pulses; GO and STOP do not alter them.
- CONFIG is legal while `is_running` = 1; it does not change `is_running`.
- `rst` mid-frame: the partial frame is discarded and all outputs return to their reset values on the next edge.
- `inst_send` and `cmd_err` are never high in the same cycle.

Optional Feature:
- Macro `TRAFFIC_CMD_CHK_EN`.
- Defined: time byte [7:4] must equal header[7:4] ^ header[3:0] ^ time[3:0]; a mismatch gives a `cmd_err` pulse, no issue, and a return to IDLE.
- Undefined: time byte [7:4] must be 0000; any other value is an error.

Test Plan:
- Reset, then hold idle -> all outputs at reset values, `input_time` = 4'hA, `inst_send` never high.
- Bytes 8'h28, then 8'h07 (5 cycles apart) -> single `inst_send` pulse 1 cycle after the second byte with `traffic_sel` 2, `color_sel` 1, `start_color` 0, `input_time` 7; `cmd_count` = 1.
- Byte 8'h40, then 8'h40, then 8'h80 -> `is_running` 1 after the first byte, still 1 after the second, 0 after the third; `cmd_count` = 3, no `cmd_err`.
- Header 8'h00 with no second byte, `TIMEOUT_CYCLES` = 16 -> `cmd_err` pulse 15 cycles after the header, state IDLE; a following 8'h40 is accepted.
- Headers 8'hC0 and 8'h01, then a CONFIG with time byte 8'h15 (checksum macro off) -> three `cmd_err` pulses, zero `inst_send`, outputs unchanged.
- `rst` asserted while in WAIT_TIME, then time byte 8'h03 -> no `inst_send`; `input_time` stays 4'hA.

Source files
------------

// File: rtl/traffic_cmd_sender.sv
// Byte-stream command parser driving the shared traffic_light configuration bus.
// Optional macro TRAFFIC_CMD_CHK_EN enables the XOR checksum on the configure time byte.
module traffic_cmd_sender #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned CNT_W          = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       inst_send,
  output logic [1:0] traffic_sel,
  output logic       color_sel,
  output logic       start_color,
  output logic [3:0] input_time,
  output logic       is_running,
  output logic       cmd_err,
  output logic [7:0] cmd_count
);

  typedef enum logic [1:0] {StIdle, StWaitTime, StIssue} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  // Held header fields: {traffic_sel, color_sel, start_color}
  logic [3:0]       r_hdr;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic             w_time_ok;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Error fires on the edge where the counter reaches TIMEOUT_CYCLES-1
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef TRAFFIC_CMD_CHK_EN
  assign w_time_ok = (rx_data[7:4] ==
                      ({2'b00, r_hdr[3:2]} ^ {r_hdr[1:0], 2'b00} ^ rx_data[3:0]));
`else
  assign w_time_ok = (rx_data[7:4] == 4'b0000);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_hdr       <= '0;
      inst_send   <= 1'b0;
      traffic_sel <= 2'd0;
      color_sel   <= 1'b0;
      start_color <= 1'b0;
      input_time  <= 4'b1010;
      is_running  <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_count   <= 8'd0;
    end else begin
      inst_send <= 1'b0;
      cmd_err   <= 1'b0;
      case (r_state)
        // ISSUE lasts one cycle and decodes a new header exactly like IDLE
        StIdle, StIssue: begin
          r_state <= StIdle;
          if (rx_valid) begin
            case (rx_data[7:6])
              2'b00: begin
                if (rx_data[1:0] == 2'b00) begin
                  r_hdr   <= rx_data[5:2];
                  r_cnt   <= '0;
                  r_state <= StWaitTime;
                end else begin
                  cmd_err <= 1'b1;
                end
              end
              2'b01: begin
                is_running <= 1'b1;
                cmd_count  <= cmd_count + 8'd1;
              end
              2'b10: begin
                is_running <= 1'b0;
                cmd_count  <= cmd_count + 8'd1;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        StWaitTime: begin
          if (rx_valid) begin
            if (w_time_ok) begin
              r_state     <= StIssue;
              inst_send   <= 1'b1;
              traffic_sel <= r_hdr[3:2];
              color_sel   <= r_hdr[1];
              start_color <= r_hdr[0];
              input_time  <= rx_data[3:0];
              cmd_count   <= cmd_count + 8'd1;
            end else begin
              cmd_err <= 1'b1;
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              cmd_err <= 1'b1;
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_cmd_sender.sv
// Directed bench for traffic_cmd_sender with a short timeout (16 cycles).
module tb_traffic_cmd_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       inst_send;
  logic [1:0] traffic_sel;
  logic       color_sel;
  logic       start_color;
  logic [3:0] input_time;
  logic       is_running;
  logic       cmd_err;
  logic [7:0] cmd_count;

  int checks   = 0;
  int failures = 0;
  int n_inst   = 0;
  int n_err    = 0;
  int n_both   = 0;

  traffic_cmd_sender #(
    .TIMEOUT_CYCLES(16),
    .CNT_W         (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .inst_send  (inst_send),
    .traffic_sel(traffic_sel),
    .color_sel  (color_sel),
    .start_color(start_color),
    .input_time (input_time),
    .is_running (is_running),
    .cmd_err    (cmd_err),
    .cmd_count  (cmd_count)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle
  always @(negedge clk) begin
    if (inst_send) n_inst++;
    if (cmd_err) n_err++;
    if (inst_send && cmd_err) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(5);

    // Reset state
    chk("rst_inst_send", inst_send, 0);
    chk("rst_traffic_sel", traffic_sel, 0);
    chk("rst_color_sel", color_sel, 0);
    chk("rst_start_color", start_color, 0);
    chk("rst_input_time", input_time, 4'hA);
    chk("rst_is_running", is_running, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_no_pulses", n_inst, 0);

    // Configure: 0x28 then 0x07 five cycles later
    send(8'h28);
    idle(4);
    chk("cfg_hdr_no_send", inst_send, 0);
    chk("cfg_hdr_sel_held", traffic_sel, 0);
    send(8'h07);
    chk("cfg_inst_send", inst_send, 1);
    chk("cfg_traffic_sel", traffic_sel, 2);
    chk("cfg_color_sel", color_sel, 1);
    chk("cfg_start_color", start_color, 0);
    chk("cfg_input_time", input_time, 7);
    chk("cfg_cmd_count", cmd_count, 1);
    tick();
    chk("cfg_pulse_end", inst_send, 0);
    chk("cfg_time_held", input_time, 7);

    // GO, GO, STOP
    send(8'h40);
    chk("go1_running", is_running, 1);
    send(8'h40);
    chk("go2_running", is_running, 1);
    chk("go2_count", cmd_count, 3);
    send(8'h80);
    chk("stop_running", is_running, 0);
    chk("stop_count", cmd_count, 4);
    chk("gostop_no_err", n_err, 0);
    chk("gostop_sel_held", traffic_sel, 2);

    // Timeout: header alone, error on the 15th edge after it
    send(8'h00);
    idle(14);
    chk("to_not_yet", cmd_err, 0);
    tick();
    chk("to_err", cmd_err, 1);
    tick();
    chk("to_err_end", cmd_err, 0);
    send(8'h40);
    chk("to_go_running", is_running, 1);
    chk("to_go_count", cmd_count, 5);
    chk("to_time_held", input_time, 7);

    // Malformed frames
    send(8'hC0);
    chk("bad_op_err", cmd_err, 1);
    send(8'h01);
    chk("bad_low_err", cmd_err, 1);
    send(8'h28);
    send(8'h15);
    chk("bad_time_err", cmd_err, 1);
    chk("bad_time_no_send", inst_send, 0);
    tick();
    chk("bad_err_total", n_err, 4);
    chk("bad_inst_total", n_inst, 1);
    chk("bad_time_held", input_time, 7);
    chk("bad_sel_held", traffic_sel, 2);
    chk("bad_count", cmd_count, 5);
    send(8'h80);
    chk("bad_then_stop", cmd_count, 6);

    // Reset in the middle of a frame
    send(8'h40);
    send(8'h34);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_running", is_running, 0);
    chk("mid_rst_count", cmd_count, 0);
    chk("mid_rst_sel", traffic_sel, 0);
    send(8'h03);
    chk("mid_rst_no_send", inst_send, 0);
    chk("mid_rst_hdr_err", cmd_err, 1);
    chk("mid_rst_time", input_time, 4'hA);

    // Header decoded during ISSUE
    send(8'h34);
    send(8'h03);
    chk("iss_send", inst_send, 1);
    chk("iss_sel", traffic_sel, 3);
    chk("iss_color", color_sel, 0);
    chk("iss_start", start_color, 1);
    chk("iss_time", input_time, 3);
    send(8'h40);
    chk("iss_go_running", is_running, 1);
    chk("iss_go_count", cmd_count, 2);
    chk("iss_send_end", inst_send, 0);
    tick();
    chk("total_inst", n_inst, 2);
    chk("never_both", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
